// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: ALU control codes, opcodes and the memory-arbiter
// state encoding with its default fetch-starvation limit.
package mips_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Consecutive data grants tolerated while a fetch waits.
    localparam int MEM_ARB_MAX_D_STREAK = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access. Data wins
// collisions until MAX_D_STREAK consecutive data grants have starved a pending fetch.
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = MEM_ARB_MAX_D_STREAK
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              if_stall,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                  STREAK_W   = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    arb_state_e          state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                is_data_q, is_data_d;
    logic                cancel_q, cancel_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                fetch_ok;
    logic                grant_i;
    logic                grant_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d     = state_q;
        streak_d    = streak_q;
        is_data_d   = is_data_q;
        cancel_d    = cancel_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        fetch_ok    = if_req & ~if_flush;

        unique case (state_q)
            IDLE: begin
                if (d_req && !(fetch_ok && streak_q == STREAK_MAX)) begin
                    grant_d = 1'b1;
                end else if (fetch_ok) begin
                    grant_i = 1'b1;
                end
            end
            BUSY_I: begin
                // A flush cannot abort the backend, so it only hides the coming ack.
                if (if_flush) begin
                    cancel_d = 1'b1;
                end
                if (mem_ready) begin
                    if_rdata_d = mem_rdata;
                    state_d    = RESP;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    d_rdata_d = mem_rdata;
                    state_d   = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (grant_d) begin
            state_d     = BUSY_D;
            is_data_d   = 1'b1;
            cancel_d    = 1'b0;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
        end else if (grant_i) begin
            state_d     = BUSY_I;
            is_data_d   = 1'b0;
            cancel_d    = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
        end

        // The streak only measures starvation of a fetch that is actually waiting.
        if (!if_req || grant_i) begin
            streak_d = '0;
        end else if (grant_d && streak_q != STREAK_MAX) begin
            streak_d = streak_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            is_data_q   <= 1'b0;
            cancel_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q     <= state_d;
            streak_q    <= streak_d;
            is_data_q   <= is_data_d;
            cancel_q    <= cancel_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_req   = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign mem_we    = (state_q == BUSY_D) && mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ack    = (state_q == RESP) && !is_data_q && !cancel_q;
    assign d_ack     = (state_q == RESP) && is_data_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_stall  = if_req & ~if_ack;
    assign d_stall   = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a bench-side backend answers mem_req, expected
// acks are queued as requests are driven and matched against the acks observed.
module tb_mem_arbiter;

    typedef struct packed {
        logic        is_data;
        logic [31:0] data;
    } ack_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } grant_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, d_req, d_we, mem_ready;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic        if_ack, d_ack, if_stall, d_stall, mem_req, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

    ack_t   exp_q[$];
    ack_t   obs_q[$];
    grant_t grant_q[$];
    ack_t   exp_a, obs_a;
    int     n_cmp       = 0;
    int     n_bad       = 0;
    int     both_acks   = 0;
    int     wait_states = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .if_stall(if_stall), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] backend_data(input logic [31:0] addr);
        return (addr == 32'h40) ? 32'h2008_000A : (addr ^ 32'hA5A5_0000);
    endfunction

    // Backend: answers after wait_states extra cycles and logs each completed transaction.
    initial begin : backend
        int cnt;
        cnt       = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (rst || !mem_req) begin
                cnt = 0;
            end else if (cnt >= wait_states) begin
                mem_ready = 1'b1;
                mem_rdata = backend_data(mem_addr);
                grant_q.push_back(grant_t'{we: mem_we, addr: mem_addr, wdata: mem_wdata});
                cnt = 0;
            end else begin
                cnt++;
            end
        end
    end

    initial begin : ack_monitor
        forever begin
            @(negedge clk);
            if (if_ack && d_ack) both_acks++;
            if (if_ack) obs_q.push_back(ack_t'{is_data: 1'b0, data: if_rdata});
            if (d_ack)  obs_q.push_back(ack_t'{is_data: 1'b1, data: d_rdata});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (2) tick();
        n_cmp++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, if_ack, d_ack, if_rdata, d_rdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h iack=%b dack=%b irdata=%h drdata=%h, required all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, if_ack, d_ack, if_rdata, d_rdata);
        end
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_fetch_alone();
        int lat, stall;
        grant_q.delete();
        lat = -1; stall = 0;
        tick();
        if_addr = 32'h40; if_req = 1'b1;
        exp_q.push_back(ack_t'{is_data: 1'b0, data: 32'h2008_000A});
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (if_stall) stall++;
            if (if_ack) begin lat = c; break; end
        end
        tick();
        if_req = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (lat !== 2) begin n_bad++; $display("FAIL fetch_latency: got %0d cycles, required 2", lat); end
        n_cmp++;
        if (stall !== 2) begin n_bad++; $display("FAIL fetch_stall: got %0d stall cycles, required 2", stall); end
        n_cmp++;
        if (grant_q.size() != 1 || grant_q[0].we !== 1'b0 || grant_q[0].addr !== 32'h40) begin
            n_bad++; $display("FAIL fetch_grant: got %0d grants, required one read of 0x40", grant_q.size());
        end
        while (exp_q.size() != 0) begin
            exp_a = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL fetch_sb: no ack seen, required data=%b rdata=%h", exp_a.is_data, exp_a.data);
            end else begin
                obs_a = obs_q.pop_front();
                if (obs_a !== exp_a) begin
                    n_bad++; $display("FAIL fetch_sb: got data=%b rdata=%h, required data=%b rdata=%h",
                                      obs_a.is_data, obs_a.data, exp_a.is_data, exp_a.data);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin n_bad++; $display("FAIL fetch_extra: got %0d extra acks, required 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_collision();
        bit   got_d, got_i, seen, ack_d_now, ack_i_now;
        logic first_we;
        grant_q.delete();
        got_d = 0; got_i = 0; seen = 0; first_we = 1'bx;
        tick();
        if_addr = 32'h40; if_req = 1'b1;
        d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
        exp_q.push_back(ack_t'{is_data: 1'b1, data: backend_data(32'h100)});
        exp_q.push_back(ack_t'{is_data: 1'b0, data: 32'h2008_000A});
        for (int c = 0; c < 40 && !(got_d && got_i); c++) begin
            @(negedge clk);
            if (mem_req && !seen) begin seen = 1; first_we = mem_we; end
            ack_d_now = d_ack; ack_i_now = if_ack;
            tick();
            if (ack_d_now) begin got_d = 1; d_req = 1'b0; end
            if (ack_i_now) begin got_i = 1; if_req = 1'b0; end
        end
        repeat (2) tick();
        n_cmp++;
        if (!(got_d && got_i)) begin n_bad++; $display("FAIL collision_timeout: got d=%b i=%b acks, required both", got_d, got_i); end
        n_cmp++;
        if (first_we !== 1'b1) begin n_bad++; $display("FAIL collision_we: got mem_we=%b on first grant, required 1", first_we); end
        n_cmp++;
        if (grant_q.size() != 2 || grant_q[0] !== grant_t'{we: 1'b1, addr: 32'h100, wdata: 32'hDEAD_BEEF}
            || grant_q[1].we !== 1'b0 || grant_q[1].addr !== 32'h40) begin
            n_bad++; $display("FAIL collision_order: got %0d grants first addr=%h, required store 0x100 then fetch 0x40",
                              grant_q.size(), (grant_q.size() > 0) ? grant_q[0].addr : 32'h0);
        end
        while (exp_q.size() != 0) begin
            exp_a = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL collision_sb: no ack seen, required data=%b rdata=%h", exp_a.is_data, exp_a.data);
            end else begin
                obs_a = obs_q.pop_front();
                if (obs_a !== exp_a) begin
                    n_bad++; $display("FAIL collision_sb: got data=%b rdata=%h, required data=%b rdata=%h",
                                      obs_a.is_data, obs_a.data, exp_a.is_data, exp_a.data);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin n_bad++; $display("FAIL collision_extra: got %0d extra acks, required 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_starvation();
        logic [31:0] exp_addr [8];
        bit          ack_i_now;
        exp_addr = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h80, 32'h200, 32'h200, 32'h200};
        grant_q.delete();
        tick();
        d_we = 1'b0; d_addr = 32'h200; d_req = 1'b1;
        if_addr = 32'h80; if_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(ack_t'{is_data: (exp_addr[i] != 32'h80), data: backend_data(exp_addr[i])});
        end
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            ack_i_now = if_ack;
            tick();
            if (ack_i_now) if_req = 1'b0;
        end
        d_req = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (grant_q.size() != 8) begin n_bad++; $display("FAIL starve_count: got %0d grants, required 8", grant_q.size()); end
        for (int i = 0; i < 8 && i < grant_q.size(); i++) begin
            n_cmp++;
            if (grant_q[i].addr !== exp_addr[i]) begin
                n_bad++; $display("FAIL starve_grant%0d: got addr %h, required %h", i, grant_q[i].addr, exp_addr[i]);
            end
        end
        while (exp_q.size() != 0) begin
            exp_a = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL starve_sb: no ack seen, required data=%b rdata=%h", exp_a.is_data, exp_a.data);
            end else begin
                obs_a = obs_q.pop_front();
                if (obs_a !== exp_a) begin
                    n_bad++; $display("FAIL starve_sb: got data=%b rdata=%h, required data=%b rdata=%h",
                                      obs_a.is_data, obs_a.data, exp_a.is_data, exp_a.data);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin n_bad++; $display("FAIL starve_extra: got %0d extra acks, required 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_wait_states();
        int req_cycles, unstable, acks;
        bit ack_d_now, busy_now;
        req_cycles = 0; unstable = 0; acks = 0;
        grant_q.delete();
        wait_states = 5;
        tick();
        d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h1234_5678; d_req = 1'b1;
        exp_q.push_back(ack_t'{is_data: 1'b1, data: backend_data(32'h300)});
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_req) begin
                req_cycles++;
                if (mem_we !== 1'b1 || mem_addr !== 32'h300 || mem_wdata !== 32'h1234_5678) unstable++;
            end
            if (d_ack) acks++;
            ack_d_now = d_ack; busy_now = mem_req;
            tick();
            if (ack_d_now) begin
                d_req = 1'b0;
            end else if (busy_now) begin
                d_we = ~d_we; d_addr = $urandom; d_wdata = $urandom;
            end
        end
        wait_states = 0;
        n_cmp++;
        if (req_cycles !== 6) begin n_bad++; $display("FAIL wait_req_len: got mem_req high %0d cycles, required 6", req_cycles); end
        n_cmp++;
        if (unstable !== 0) begin n_bad++; $display("FAIL wait_stable: got %0d cycles with changed mem_* outputs, required 0", unstable); end
        n_cmp++;
        if (acks !== 1) begin n_bad++; $display("FAIL wait_acks: got %0d d_acks, required 1", acks); end
        while (exp_q.size() != 0) begin
            exp_a = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL wait_sb: no ack seen, required data=%b rdata=%h", exp_a.is_data, exp_a.data);
            end else begin
                obs_a = obs_q.pop_front();
                if (obs_a !== exp_a) begin
                    n_bad++; $display("FAIL wait_sb: got data=%b rdata=%h, required data=%b rdata=%h",
                                      obs_a.is_data, obs_a.data, exp_a.is_data, exp_a.data);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin n_bad++; $display("FAIL wait_extra: got %0d extra acks, required 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_flush();
        int iacks, lat;
        iacks = 0; lat = -1;
        grant_q.delete();
        wait_states = 2;
        tick();
        if_addr = 32'h44; if_req = 1'b1; if_flush = 1'b1;
        tick();
        if_flush = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mem_req !== 1'b0) begin n_bad++; $display("FAIL flush_idle: got mem_req=%b after flushed request, required 0", mem_req); end
        tick();
        if_flush = 1'b1; if_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mem_req !== 1'b1) begin n_bad++; $display("FAIL flush_busy: got mem_req=%b during fetch, required 1", mem_req); end
        tick();
        if_flush = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (if_ack) iacks++;
        end
        n_cmp++;
        if (iacks !== 0) begin n_bad++; $display("FAIL flush_ack: got %0d if_acks, required 0", iacks); end
        n_cmp++;
        if (grant_q.size() != 1 || grant_q[0].addr !== 32'h44) begin
            n_bad++; $display("FAIL flush_complete: got %0d completed transactions, required one at 0x44", grant_q.size());
        end
        n_cmp++;
        if (mem_req !== 1'b0) begin n_bad++; $display("FAIL flush_idle_after: got mem_req=%b, required 0", mem_req); end
        wait_states = 0;
        tick();
        if_addr = 32'h40; if_req = 1'b1;
        exp_q.push_back(ack_t'{is_data: 1'b0, data: 32'h2008_000A});
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (if_ack) begin lat = c; break; end
        end
        tick();
        if_req = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (lat !== 2) begin n_bad++; $display("FAIL flush_refetch: got latency %0d, required 2", lat); end
        while (exp_q.size() != 0) begin
            exp_a = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL flush_sb: no ack seen, required data=%b rdata=%h", exp_a.is_data, exp_a.data);
            end else begin
                obs_a = obs_q.pop_front();
                if (obs_a !== exp_a) begin
                    n_bad++; $display("FAIL flush_sb: got data=%b rdata=%h, required data=%b rdata=%h",
                                      obs_a.is_data, obs_a.data, exp_a.is_data, exp_a.data);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin n_bad++; $display("FAIL flush_extra: got %0d extra acks, required 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_reset_mid();
        int dacks, reqs;
        bit busy;
        dacks = 0; reqs = 0; busy = 0;
        wait_states = 3;
        tick();
        d_we = 1'b0; d_addr = 32'h500; d_req = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mem_req) begin busy = 1; break; end
        end
        n_cmp++;
        if (!busy) begin n_bad++; $display("FAIL rst_mid_grant: got no grant within 10 cycles, required mem_req=1"); end
        #2;
        rst = 1'b1;
        d_req = 1'b0;
        #1;
        n_cmp++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, d_ack, if_rdata, d_rdata} !== '0) begin
            n_bad++; $display("FAIL rst_mid_async: got req=%b addr=%h irdata=%h drdata=%h before any edge, required all 0",
                              mem_req, mem_addr, if_rdata, d_rdata);
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        wait_states = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (d_ack) dacks++;
            if (mem_req) reqs++;
        end
        n_cmp++;
        if (dacks !== 0) begin n_bad++; $display("FAIL rst_mid_ack: got %0d d_acks after reset, required 0", dacks); end
        n_cmp++;
        if (reqs !== 0) begin n_bad++; $display("FAIL rst_mid_req: got mem_req high %0d cycles after reset, required 0", reqs); end
        n_cmp++;
        if (obs_q.size() != 0) begin n_bad++; $display("FAIL rst_mid_extra: got %0d acks, required 0", obs_q.size()); obs_q.delete(); end
    endtask

    initial begin
        test_reset();
        test_fetch_alone();
        test_collision();
        test_starvation();
        test_wait_states();
        test_flush();
        test_reset_mid();
        n_cmp++;
        if (both_acks !== 0) begin n_bad++; $display("FAIL ack_exclusive: got %0d cycles with both acks, required 0", both_acks); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
